// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// funct codes, ALU operation codes and datapath select values.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUCTL_W = 5;
    localparam int unsigned ALUOP_W  = 2;
    localparam int unsigned SRCB_W   = 3;
    localparam int unsigned PCSRC_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMM_EX   = 4'd9,
        S_IMM_WB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_XOR = 6'h26;
    localparam logic [FUNCT_W-1:0] FN_NOR = 6'h27;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    typedef enum logic [ALUCTL_W-1:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_SLT = 5'd4,
        ALU_XOR = 5'd5,
        ALU_NOR = 5'd6
    } alu_ctl_t;

    typedef enum logic [ALUOP_W-1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_SUB    = 2'b01,
        ALUOP_FUNCT  = 2'b10,
        ALUOP_OPCODE = 2'b11
    } alu_op_t;

    typedef enum logic [SRCB_W-1:0] {
        SRCB_B       = 3'd0,
        SRCB_FOUR    = 3'd1,
        SRCB_SIMM    = 3'd2,
        SRCB_SIMM_SH = 3'd3,
        SRCB_ZIMM    = 3'd4
    } srcb_t;

    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_ALU    = 2'd0,
        PCSRC_ALUOUT = 2'd1,
        PCSRC_JUMP   = 2'd2
    } pcsrc_t;

    // True for the R-type funct codes this datapath implements
    function automatic logic funct_legal(input logic [FUNCT_W-1:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) || (f == FN_OR) ||
               (f == FN_XOR) || (f == FN_NOR) || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Instruction fields in, datapath controls out; master = control unit,
// slave = datapath.
interface multicycle_ctrl_fsm_if;

    logic [mips_ctrl_pkg::OP_W-1:0]     Op;
    logic [mips_ctrl_pkg::FUNCT_W-1:0]  Funct;
    logic                               MemtoReg;
    logic                               RegDst;
    logic                               lorD;
    logic [mips_ctrl_pkg::PCSRC_W-1:0]  PCSrc;
    logic [mips_ctrl_pkg::SRCB_W-1:0]   ALUSrcB;
    logic                               ALUSrcA;
    logic                               IRWrite;
    logic                               MemWrite;
    logic                               PCWrite;
    logic                               RegWrite;
    logic                               Branch;
    logic                               Branch2;
    logic [mips_ctrl_pkg::ALUOP_W-1:0]  ALUOp;
    logic [mips_ctrl_pkg::ALUCTL_W-1:0] ALUControl;
    logic [mips_ctrl_pkg::STATE_W-1:0]  state;
    logic                               illegal;

    modport master (
        input  Op, Funct,
        output MemtoReg, RegDst, lorD, PCSrc, ALUSrcB, ALUSrcA,
               IRWrite, MemWrite, PCWrite, RegWrite, Branch, Branch2,
               ALUOp, ALUControl, state, illegal
    );

    modport slave (
        output Op, Funct,
        input  MemtoReg, RegDst, lorD, PCSrc, ALUSrcB, ALUSrcA,
               IRWrite, MemWrite, PCWrite, RegWrite, Branch, Branch2,
               ALUOp, ALUControl, state, illegal
    );

endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: (ALUOp, opcode, funct) -> ALU operation code.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t              alu_op,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    output alu_ctl_t             alu_control_c
);

    // Any combination not listed falls back to ADD
    always_comb begin
        alu_control_c = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control_c = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control_c = ALU_ADD;
                    FN_SUB:  alu_control_c = ALU_SUB;
                    FN_AND:  alu_control_c = ALU_AND;
                    FN_OR:   alu_control_c = ALU_OR;
                    FN_SLT:  alu_control_c = ALU_SLT;
                    FN_XOR:  alu_control_c = ALU_XOR;
                    FN_NOR:  alu_control_c = ALU_NOR;
                    default: alu_control_c = ALU_ADD;
                endcase
            end
            ALUOP_OPCODE: begin
                case (op)
                    OP_ADDI: alu_control_c = ALU_ADD;
                    OP_ANDI: alu_control_c = ALU_AND;
                    OP_ORI:  alu_control_c = ALU_OR;
                    OP_SLTI: alu_control_c = ALU_SLT;
                    default: alu_control_c = ALU_ADD;
                endcase
            end
            default: alu_control_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS main control: opcode/funct capture, Moore sequencing FSM
// and decode of every datapath select and write enable.
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_fsm_if.master bus
);

    state_t               state_q;
    state_t               state_d;
    logic [OP_W-1:0]      op_q;
    logic [FUNCT_W-1:0]   funct_q;

    logic                 mem_to_reg_c;
    logic                 reg_dst_c;
    logic                 lor_d_c;
    pcsrc_t               pc_src_c;
    srcb_t                alu_src_b_c;
    logic                 alu_src_a_c;
    logic                 ir_write_c;
    logic                 mem_write_c;
    logic                 pc_write_c;
    logic                 reg_write_c;
    logic                 branch_c;
    logic                 branch2_c;
    alu_op_t              alu_op_c;
    logic                 illegal_c;
    alu_ctl_t             alu_ctl_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction fields are captured only while the IR is being written
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q    <= '0;
            funct_q <= '0;
        end else if (bus.IRWrite) begin
            op_q    <= bus.Op;
            funct_q <= bus.Funct;
        end
    end

    always_comb begin
        state_d      = S_FETCH;
        mem_to_reg_c = 1'b0;
        reg_dst_c    = 1'b0;
        lor_d_c      = 1'b0;
        pc_src_c     = PCSRC_ALU;
        alu_src_b_c  = SRCB_B;
        alu_src_a_c  = 1'b0;
        ir_write_c   = 1'b0;
        mem_write_c  = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        branch_c     = 1'b0;
        branch2_c    = 1'b0;
        alu_op_c     = ALUOP_ADD;
        illegal_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b_c = SRCB_FOUR;
                ir_write_c  = 1'b1;
                pc_write_c  = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_c = SRCB_SIMM_SH;
                case (op_q)
                    OP_LW, OP_SW:                    state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMM_EX;
                    OP_J:                            state_d = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_legal(funct_q)) begin
                            state_d = S_RTYPE_EX;
                        end else begin
                            illegal_c = 1'b1;
                        end
                    end
                    default: illegal_c = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRCB_SIMM;
                state_d     = (op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                lor_d_c = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
            end
            S_MEMWRITE: begin
                lor_d_c     = 1'b1;
                mem_write_c = 1'b1;
            end
            S_RTYPE_EX: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_dst_c   = 1'b1;
                reg_write_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALUOP_SUB;
                pc_src_c    = PCSRC_ALUOUT;
                branch_c    = (op_q == OP_BEQ);
                branch2_c   = (op_q == OP_BNE);
            end
            S_IMM_EX: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALUOP_OPCODE;
                alu_src_b_c = ((op_q == OP_ANDI) || (op_q == OP_ORI)) ? SRCB_ZIMM : SRCB_SIMM;
                state_d     = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write_c = 1'b1;
            end
            S_JUMP: begin
                pc_src_c   = PCSRC_JUMP;
                pc_write_c = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op        (alu_op_c),
        .op            (op_q),
        .funct         (funct_q),
        .alu_control_c (alu_ctl_c)
    );

    // Enables and the illegal flag are held low for the whole reset cycle
    assign bus.IRWrite    = reset & ir_write_c;
    assign bus.MemWrite   = reset & mem_write_c;
    assign bus.PCWrite    = reset & pc_write_c;
    assign bus.RegWrite   = reset & reg_write_c;
    assign bus.Branch     = reset & branch_c;
    assign bus.Branch2    = reset & branch2_c;
    assign bus.illegal    = reset & illegal_c;

    assign bus.MemtoReg   = mem_to_reg_c;
    assign bus.RegDst     = reg_dst_c;
    assign bus.lorD       = lor_d_c;
    assign bus.PCSrc      = pc_src_c;
    assign bus.ALUSrcB    = alu_src_b_c;
    assign bus.ALUSrcA    = alu_src_a_c;
    assign bus.ALUOp      = alu_op_c;
    assign bus.ALUControl = alu_ctl_c;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: the stimulus queues hand-written
// per-cycle output vectors, a negedge monitor pops and compares them.
module tb_multicycle_ctrl_fsm;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       lor_d;
        logic [1:0] pc_src;
        logic [2:0] src_b;
        logic       src_a;
        logic       ir_w;
        logic       mem_w;
        logic       pc_w;
        logic       reg_w;
        logic       br;
        logic       br2;
        logic [1:0] alu_op;
        logic [4:0] alu_ctl;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t  sb[$];
    string tags[$];
    int    checks = 0;
    int    errors = 0;

    // Hand table of Moore outputs per state; ALUControl defaults to ADD(0)
    function automatic exp_t base(input int st);
        exp_t e;
        e    = '0;
        e.st = 4'(st);
        case (st)
            0:  begin e.src_b = 3'd1; e.ir_w = 1'b1; e.pc_w = 1'b1; end
            1:  begin e.src_b = 3'd3; end
            2:  begin e.src_a = 1'b1; e.src_b = 3'd2; end
            3:  begin e.lor_d = 1'b1; end
            4:  begin e.mem_to_reg = 1'b1; e.reg_w = 1'b1; end
            5:  begin e.lor_d = 1'b1; e.mem_w = 1'b1; end
            6:  begin e.src_a = 1'b1; e.alu_op = 2'b10; end
            7:  begin e.reg_dst = 1'b1; e.reg_w = 1'b1; end
            8:  begin e.src_a = 1'b1; e.alu_op = 2'b01; e.pc_src = 2'd1; e.alu_ctl = 5'd1; end
            9:  begin e.src_a = 1'b1; e.alu_op = 2'b11; end
            10: begin e.reg_w = 1'b1; end
            11: begin e.pc_src = 2'd2; e.pc_w = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic exp_t actual();
        return {bus.state, bus.MemtoReg, bus.RegDst, bus.lorD, bus.PCSrc,
                bus.ALUSrcB, bus.ALUSrcA, bus.IRWrite, bus.MemWrite,
                bus.PCWrite, bus.RegWrite, bus.Branch, bus.Branch2,
                bus.ALUOp, bus.ALUControl, bus.illegal};
    endfunction

    always @(negedge clk) begin : monitor
        exp_t  e;
        exp_t  a;
        string t;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            t = tags.pop_front();
            a = actual();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                         t, a, a.st, e, e.st);
            end
        end
    end

    task automatic cyc(input string t, input exp_t e);
        sb.push_back(e);
        tags.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string t, input logic [5:0] op, input logic [5:0] fn);
        bus.Op    = op;
        bus.Funct = fn;
        cyc({t, "/fetch"}, base(0));
    endtask

    task automatic fetch_decode(input string t, input logic [5:0] op, input logic [5:0] fn);
        fetch(t, op, fn);
        cyc({t, "/decode"}, base(1));
    endtask

    task automatic imm_instr(input string t, input logic [5:0] op,
                             input logic [2:0] srcb, input logic [4:0] ctl);
        exp_t e;
        fetch_decode(t, op, 6'h00);
        e = base(9); e.src_b = srcb; e.alu_ctl = ctl;
        cyc({t, "/imm_ex"}, e);
        cyc({t, "/imm_wb"}, base(10));
    endtask

    task automatic r_instr(input string t, input logic [5:0] fn, input logic [4:0] ctl);
        exp_t e;
        fetch_decode(t, 6'h00, fn);
        e = base(6); e.alu_ctl = ctl;
        cyc({t, "/rtype_ex"}, e);
        cyc({t, "/alu_wb"}, base(7));
    endtask

    initial begin : stim
        exp_t e;
        reset     = 1'b0;
        bus.Op    = 6'h23;
        bus.Funct = 6'h00;
        @(posedge clk);
        #1;
        // Second reset cycle: FETCH selects, all enables suppressed
        e = base(0); e.ir_w = 1'b0; e.pc_w = 1'b0;
        cyc("reset", e);
        reset = 1'b1;

        fetch_decode("lw", 6'h23, 6'h00);
        cyc("lw/memadr", base(2));
        cyc("lw/memread", base(3));
        cyc("lw/memwb", base(4));

        fetch_decode("sw", 6'h2B, 6'h00);
        cyc("sw/memadr", base(2));
        cyc("sw/memwrite", base(5));

        r_instr("sub", 6'h22, 5'd1);
        r_instr("xor", 6'h26, 5'd5);
        r_instr("slt", 6'h2A, 5'd4);
        r_instr("nor", 6'h27, 5'd6);

        fetch_decode("beq", 6'h04, 6'h00);
        e = base(8); e.br = 1'b1;
        cyc("beq/branch", e);
        fetch_decode("bne", 6'h05, 6'h00);
        e = base(8); e.br2 = 1'b1;
        cyc("bne/branch", e);

        imm_instr("ori",  6'h0D, 3'd4, 5'd3);
        imm_instr("andi", 6'h0C, 3'd4, 5'd2);
        imm_instr("addi", 6'h08, 3'd2, 5'd0);
        imm_instr("slti", 6'h0A, 3'd2, 5'd4);

        fetch_decode("j", 6'h02, 6'h00);
        cyc("j/jump", base(11));

        fetch("ill_op", 6'h3F, 6'h00);
        e = base(1); e.ill = 1'b1;
        cyc("ill_op/decode", e);
        fetch("ill_fn", 6'h00, 6'h3F);
        e = base(1); e.ill = 1'b1;
        cyc("ill_fn/decode", e);

        // Op/Funct wiggling after FETCH must not disturb a lw
        fetch("lw_noise", 6'h23, 6'h00);
        bus.Op = 6'h02;
        cyc("lw_noise/decode", base(1));
        bus.Op = 6'h3F; bus.Funct = 6'h22;
        cyc("lw_noise/memadr", base(2));
        bus.Op = 6'h2B;
        cyc("lw_noise/memread", base(3));
        cyc("lw_noise/memwb", base(4));

        // Reset during MEMREAD aborts the lw
        fetch_decode("abort3", 6'h23, 6'h00);
        cyc("abort3/memadr", base(2));
        reset = 1'b0;
        cyc("abort3/memread", base(3));
        reset = 1'b1;
        cyc("abort3/refetch", base(0));
        cyc("abort3/decode", base(1));
        cyc("abort3/memadr2", base(2));
        cyc("abort3/memread2", base(3));
        reset = 1'b0;
        // Reset during MEMWB suppresses RegWrite
        e = base(4); e.reg_w = 1'b0;
        cyc("abort4/memwb", e);
        reset = 1'b1;

        fetch_decode("beq_rst", 6'h04, 6'h00);
        reset = 1'b0;
        e = base(8);
        cyc("beq_rst/branch", e);
        reset = 1'b1;

        fetch_decode("j2", 6'h02, 6'h00);
        cyc("j2/jump", base(11));

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Main control unit for the multi-cycle MIPS datapath. It sits directly upstream of the datapath: it captures opcode/funct when the instruction is fetched, sequences each instruction through a Moore FSM, and drives every mux select, write enable and ALU operation code the datapath consumes. It supports R-type (add/sub/and/or/slt/xor/nor), lw, sw, beq, bne, addi, andi, ori, slti and j.

## Interface
Parameters:
- none; all encodings come from the shared package.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  active-low synchronous reset
- Op  in  6  Instr[31:26] from memory read data; sampled only when IRWrite=1
- Funct  in  6  Instr[5:0]; sampled only when IRWrite=1
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = Data
- RegDst  out  1  destination register select: 0 = rt, 1 = rd
- lorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- PCSrc  out  2  next PC select: 0 = ALUResult, 1 = ALUOut, 2 = jump target
- ALUSrcB  out  3  ALU B select: 0 = B, 1 = 4, 2 = Signimm, 3 = Signimm<<2, 4 = zero-extended imm
- ALUSrcA  out  1  ALU A select: 0 = PC, 1 = A
- IRWrite, MemWrite, PCWrite, RegWrite  out  1 each  write enables
- Branch  out  1  beq: PC update when Zero
- Branch2  out  1  bne: PC update when !Zero
- ALUOp  out  2  00 add, 01 sub, 10 use funct, 11 use opcode
- ALUControl  out  5  operation code to ALU
- state  out  4  current state (debug)
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode/funct

## Operation
- Opcode/funct register: loads Op/Funct on any clock edge where IRWrite=1. All decode uses the registered copy.
- States and outputs. Unlisted enables = 0; unlisted selects = 0; ALUOp = 00 unless stated.
  - FETCH(0): ALUSrcB=1, IRWrite=1, PCWrite=1. Next state: DECODE.
  - DECODE(1): ALUSrcB=3. Next state: lw/sw→MEMADR; R-type with legal funct→RTYPE_EX; beq/bne→BRANCH; addi/andi/ori/slti→IMM_EX; j→JUMP; otherwise→FETCH with illegal=1.
  - MEMADR(2): ALUSrcA=1, ALUSrcB=2. Next state: lw→MEMREAD, sw→MEMWRITE.
  - MEMREAD(3): lorD=1. Next state: MEMWB.
  - MEMWB(4): MemtoReg=1, RegWrite=1. Next state: FETCH.
  - MEMWRITE(5): lorD=1, MemWrite=1. Next state: FETCH.
  - RTYPE_EX(6): ALUSrcA=1, ALUSrcB=0, ALUOp=10. Next state: ALU_WB.
  - ALU_WB(7): RegDst=1, RegWrite=1. Next state: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUOp=01, PCSrc=1, Branch=(op==beq), Branch2=(op==bne). Next state: FETCH.
  - IMM_EX(9): ALUSrcA=1, ALUOp=11, ALUSrcB=4 for andi/ori and 2 for addi/slti. Next state: IMM_WB.
  - IMM_WB(10): RegWrite=1. Next state: FETCH.
  - JUMP(11): PCSrc=2, PCWrite=1. Next state: FETCH.
  - Codes 12–15 are unreachable and go to FETCH.
- ALUControl mapping:
  - ALUOp 00 → ADD; 01 → SUB.
  - ALUOp 10 → funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100110 XOR, 100111 NOR.
  - ALUOp 11 → addi ADD, andi AND, ori OR, slti SLT.
  - Any unmapped combination → ADD.

## Timing
- Moore outputs, decoded combinationally from the state register (and the opcode register where noted). No output latency beyond the state register.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi-class 4, beq/bne 3, j 3, illegal 2.
- Reset:
  - While reset=0, IRWrite, PCWrite, MemWrite, RegWrite, Branch, Branch2 and illegal are forced to 0 combinationally.
  - On the edge sampled with reset=0: state←FETCH and opcode/funct register←0.
  - After release, state=0 and all selects take FETCH values.
- Reset asserted mid-instruction aborts the instruction; no write enable is asserted in the reset cycle.
- Op/Funct changes outside FETCH have no effect on sequencing.

## Structure
- Package mips_ctrl_pkg holds:
  - state encoding (4-bit enum, values as above);
  - opcode and funct constants;
  - ALUControl codes (ADD=0, SUB=1, AND=2, OR=3, SLT=4, XOR=5, NOR=6);
  - ALUSrcB, PCSrc and ALUOp encodings.
- Sub-module alu_decoder: purely combinational, maps (ALUOp, op, funct) to ALUControl. The FSM, opcode register and output decode live in the top module.

## Test plan
- Reset held low for 2 cycles, Op=6'h23 → state=0; PCWrite=IRWrite=RegWrite=MemWrite=0 during reset; first cycle after release: IRWrite=PCWrite=1, ALUSrcB=1.
- lw (Op=100011) → states 0,1,2,3,4,0; lorD=1 in state 3; MemtoReg=RegWrite=1 in state 4 only; total 5 cycles.
- R-type sub (Op=0, Funct=100010) → states 0,1,6,7; ALUControl=SUB in state 6; RegDst=1 and RegWrite=1 in state 7.
- beq then bne → state 8 with Branch=1/Branch2=0, then Branch=0/Branch2=1; ALUControl=SUB; PCSrc=1; 3 cycles each.
- ori (Op=001101) → ALUSrcB=4 and ALUControl=OR in state 9; j (Op=000010) → state 11 with PCSrc=2, PCWrite=1.
- Op=6'h3F → illegal=1 in DECODE, then FETCH; reset driven low during state 3 of lw → no RegWrite pulse, state=0 next cycle.
